// File: rtl/adder_share_ctrl.sv
// Arbitrates two requesters onto one shared combinational adder.
// Operands are registered, held for a settle window, then the sum is returned.
module adder_share_ctrl #(
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  input  logic [WIDTH-1:0] ADD_SUM,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESP_SUM,
  output logic             RESP_ID,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESPOND
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q, id_d;
  logic             vld_q, vld_d;

  logic idle;
  logic gnt0;
  logic gnt1;

  // Round-robin grant: on contention the requester opposite the pointer wins.
  always_comb begin
    idle = (state_q == IDLE);
    gnt0 = REQ0_VALID & (~REQ1_VALID | ptr_q);
    gnt1 = REQ1_VALID & (~REQ0_VALID | ~ptr_q);
    REQ0_READY = idle & gnt0;
    REQ1_READY = idle & gnt1;
  end

  // Next-state logic for the accept / settle / respond sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    sum_d   = sum_q;
    id_d    = id_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          add_a_d = gnt1 ? REQ1_A : REQ0_A;
          add_b_d = gnt1 ? REQ1_B : REQ0_B;
          ptr_d   = gnt1;
          id_d    = gnt1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) begin
          sum_d   = ADD_SUM;
          vld_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESPOND: begin
        if (RESP_READY) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; pointer resets so requester 0 wins first.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 1'b1;
      add_a_q <= '0;
      add_b_q <= '0;
      sum_q   <= '0;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
    end
  end

  assign ADD_A      = add_a_q;
  assign ADD_B      = add_b_q;
  assign RESP_VALID = vld_q;
  assign RESP_SUM   = sum_q;
  assign RESP_ID    = id_q;
  assign BUSY       = (state_q != IDLE);

endmodule
